mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width of all ports.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ifu_req_valid  input  1; ifu_req_ready  output  1; ifu_addr  input  ADDR_W: instruction-fetch request (read only).
REQ-006 SHALL have ports ifu_resp_valid  output  1; ifu_rdata  output  DATA_W: instruction-fetch response.
REQ-007 SHALL have ports lsu_req_valid  input  1; lsu_req_ready  output  1; lsu_addr  input  ADDR_W; lsu_wen  input  1; lsu_wdata  input  DATA_W; lsu_wmask  input  8: load/store request.
REQ-008 SHALL have ports lsu_resp_valid  output  1; lsu_rdata  output  DATA_W: load data or store acknowledge.
REQ-009 SHALL have ports mem_req_valid  output  1; mem_req_ready  input  1; mem_addr  output  ADDR_W; mem_wen  output  1; mem_wdata  output  DATA_W; mem_wmask  output  8: shared memory request.
REQ-010 SHALL have ports mem_resp_valid  input  1; mem_rdata  input  DATA_W: shared memory response.

Function
REQ-011 SHALL implement FSM states IDLE, REQ, WAIT; exactly one outstanding transaction.
REQ-012 IDLE: SHALL assert ready only to the granted requester; grant computed combinationally from current valids and priority; ready of the non-granted requester 0.
REQ-013 Acceptance (valid & ready in IDLE) SHALL capture addr/wen/wdata/wmask and owner ID into registers and move to REQ next cycle; IFU captures wen=0, wmask=0.
REQ-014 REQ: SHALL drive mem_req_valid=1 with captured fields, stable until mem_req_ready=1; on that edge move to WAIT.
REQ-015 WAIT: mem_req_valid=0; on mem_resp_valid=1, SHALL assert owner's resp_valid for that same cycle with rdata = mem_rdata, and move to IDLE next cycle.
REQ-016 Non-owner resp_valid SHALL be 0 always; ifu_rdata/lsu_rdata SHALL be 0 when their resp_valid is 0.
REQ-017 Minimum turnaround: accept cycle N, mem_req_valid cycle N+1, response earliest cycle N+2, next acceptance earliest cycle N+3.
REQ-018 mem_resp_valid in IDLE or REQ SHALL be ignored (no resp_valid, no state change).
REQ-019 Both valids asserted simultaneously in IDLE: exactly one granted per priority rule; the other stays not-ready until a later IDLE cycle.
REQ-020 Requester deasserting valid before acceptance SHALL cause no transaction; grant re-evaluated every IDLE cycle.
REQ-021 Store responses (wen=1) SHALL still produce lsu_resp_valid pulse; lsu_rdata = mem_rdata.

Reset
REQ-022 rst=1 at any edge SHALL force state IDLE, clear captured registers and owner, set round-robin pointer to favour LSU.
REQ-023 During and one cycle after... during rst=1, all outputs SHALL be 0 (ready, valid, resp_valid, mem_* fields).
REQ-024 Reset mid-transaction SHALL abandon it: no response delivered; a mem_resp_valid arriving after reset, in IDLE, is ignored per REQ-018.

Configuration
REQ-025 Macro MEM_ARB_RR_EN undefined: fixed priority, LSU always wins over IFU.
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin; 1-bit pointer updated on each acceptance so the other requester has priority next; pointer only breaks ties, a lone valid is always granted.

Verification
REQ-027 IFU only: ifu_addr=0x80000000, mem_req_ready=1, mem_rdata=0x00100073 one cycle after REQ -> mem_addr=0x80000000 at N+1, ifu_resp_valid=1 with ifu_rdata=0x00100073 at N+2, lsu_resp_valid=0.
REQ-028 Simultaneous IFU and LSU valid, macro off, repeated 3 times -> LSU granted all 3 times, IFU never ready while LSU valid.
REQ-029 Simultaneous valids, MEM_ARB_RR_EN on, 4 transactions -> grant order LSU, IFU, LSU, IFU.
REQ-030 LSU store addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F, mem_req_ready low 3 cycles -> mem_* fields stable 4 cycles in REQ, lsu_resp_valid pulse after mem_resp_valid.
REQ-031 rst asserted in WAIT, then mem_resp_valid=1 after release -> no ifu/lsu resp_valid, state IDLE, next request served normally.
REQ-032 mem_resp_valid=1 while IDLE with no request -> no resp_valid, ready behaviour unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port (IFU) and a load/store
// port (LSU) onto a single memory port with one outstanding transaction.
// Default build: fixed priority, LSU always wins over IFU.
// Define MEM_ARB_RR_EN to get round-robin tie-breaking between the two.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch request / response (read only)
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    // load/store request / response
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    // shared memory port
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic              owner_lsu;   // 1: transaction belongs to LSU, 0: IFU
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
`ifdef MEM_ARB_RR_EN
    logic              rr_lsu;      // 1: LSU wins the next tie
`endif

    logic grant_lsu;
    logic grant_ifu;
    logic req_active;
    logic resp_fire;

    // Grant is decided every IDLE cycle from the current valids; nothing is granted in reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        grant_lsu = 1'b0;
        grant_ifu = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef MEM_ARB_RR_EN
            if (lsu_req_valid && ifu_req_valid) begin
                grant_lsu = rr_lsu;
                grant_ifu = !rr_lsu;
            end else begin
                grant_lsu = lsu_req_valid;
                grant_ifu = ifu_req_valid;
            end
`else
            grant_lsu = lsu_req_valid;
            grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
        end
    end

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    // Memory request fields are only visible while the request is being presented.
    assign req_active    = (state == REQ) && !rst;
    assign mem_req_valid = req_active;
    assign mem_addr      = req_active ? addr_q  : '0;
    assign mem_wen       = req_active ? wen_q   : 1'b0;
    assign mem_wdata     = req_active ? wdata_q : '0;
    assign mem_wmask     = req_active ? wmask_q : 8'h00;

    // A response is only meaningful while waiting for one; stray responses elsewhere are dropped.
    assign resp_fire      = (state == WAIT) && mem_resp_valid && !rst;
    assign ifu_resp_valid = resp_fire && !owner_lsu;
    assign lsu_resp_valid = resp_fire && owner_lsu;
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;

    // Transaction FSM: capture on acceptance, present request, wait for response.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= 8'h00;
`ifdef MEM_ARB_RR_EN
            rr_lsu    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_lsu) begin
                        state     <= REQ;
                        owner_lsu <= 1'b1;
                        addr_q    <= lsu_addr;
                        wen_q     <= lsu_wen;
                        wdata_q   <= lsu_wdata;
                        wmask_q   <= lsu_wmask;
`ifdef MEM_ARB_RR_EN
                        rr_lsu    <= 1'b0;
`endif
                    end else if (grant_ifu) begin
                        state     <= REQ;
                        owner_lsu <= 1'b0;
                        addr_q    <= ifu_addr;
                        wen_q     <= 1'b0;
                        wdata_q   <= '0;
                        wmask_q   <= 8'h00;
`ifdef MEM_ARB_RR_EN
                        rr_lsu    <= 1'b1;
`endif
                    end
                end
                REQ: begin
                    if (mem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (mem_resp_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
